// File: rtl/usr_mode_sequencer_if.sv
// Command and register-side signal bundle for usr_mode_sequencer.
//   cmd_valid/cmd_ready/cmd_op/cmd_count/cmd_data : command handshake
//   abort                                         : cancel the running command
//   ser_in_r/ser_in_l, ser_out_r/ser_out_l        : serial ports of the register
//   mode_sel, q                                   : mux select and register contents
//   busy/done/aborted                             : status
interface usr_mode_sequencer_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [CNT_W-1:0] cmd_count;
    logic [WIDTH-1:0] cmd_data;
    logic             abort;
    logic             ser_in_r;
    logic             ser_in_l;
    logic [1:0]       mode_sel;
    logic [WIDTH-1:0] q;
    logic             ser_out_r;
    logic             ser_out_l;
    logic             busy;
    logic             done;
    logic             aborted;

    // Command source / register consumer side.
    modport master (
        output cmd_valid, cmd_op, cmd_count, cmd_data, abort, ser_in_r, ser_in_l,
        input  cmd_ready, mode_sel, q, ser_out_r, ser_out_l, busy, done, aborted
    );

    // Sequencer side.
    modport slave (
        input  cmd_valid, cmd_op, cmd_count, cmd_data, abort, ser_in_r, ser_in_l,
        output cmd_ready, mode_sel, q, ser_out_r, ser_out_l, busy, done, aborted
    );
endinterface

// File: rtl/usr_mode_sequencer.sv
// Command-driven sequencer for a universal shift register.
// Accepts HOLD/SHR/SHL/LOAD commands, applies each for a programmed number of
// cycles while driving the 4:1 mode-mux select, then pulses done.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : usr_mode_sequencer_if slave (command, serial, status signals)
module usr_mode_sequencer #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    usr_mode_sequencer_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        OP_HOLD = 2'd0,
        OP_SHR  = 2'd1,
        OP_SHL  = 2'd2,
        OP_LOAD = 2'd3
    } op_e;

    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [1:0]       mode_sel_q, mode_sel_d;
    logic             cmd_ready_q, cmd_ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             aborted_q, aborted_d;

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            op_q        <= OP_HOLD;
            data_q      <= '0;
            q_q         <= '0;
            rem_q       <= '0;
            mode_sel_q  <= 2'd0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            data_q      <= data_d;
            q_q         <= q_d;
            rem_q       <= rem_d;
            mode_sel_q  <= mode_sel_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            aborted_q   <= aborted_d;
        end
    end

    // Next-state, datapath and next-output logic.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        data_d    = data_q;
        q_d       = q_q;
        rem_d     = rem_q;
        aborted_d = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    op_d   = op_e'(bus.cmd_op);
                    data_d = bus.cmd_data;
                    rem_d  = (op_e'(bus.cmd_op) == OP_LOAD) ? CNT_W'(1) : bus.cmd_count;
                    state_d = (rem_d == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (bus.abort) begin
                    // Abort wins over the op: register untouched on this edge.
                    state_d   = S_DONE;
                    aborted_d = 1'b1;
                end else begin
                    unique case (op_q)
                        OP_HOLD: q_d = q_q;
                        OP_SHR:  q_d = {bus.ser_in_r, q_q[WIDTH-1:1]};
                        OP_SHL:  q_d = {q_q[WIDTH-2:0], bus.ser_in_l};
                        OP_LOAD: q_d = data_q;
                        default: q_d = q_q;
                    endcase
                    // RUN is only entered with rem >= 1, so this never wraps.
                    rem_d = rem_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1)) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are registered copies of what the next state implies.
        cmd_ready_d = (state_d == S_IDLE);
        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_DONE);
        mode_sel_d  = (state_d == S_RUN) ? 2'(op_d) : 2'd0;
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.mode_sel  = mode_sel_q;
    assign bus.q         = q_q;
    assign bus.ser_out_r = q_q[0];
    assign bus.ser_out_l = q_q[WIDTH-1];
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.aborted   = aborted_q;

endmodule
